div_32: RTL

DIV_32 -- requirements
Module: div_32

---
 rtl/div_32.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/div_32.sv
// 32-bit sequential restoring divider: one quotient bit per cycle, MSB first.
// Define DIV_32_SIGNED_EN to add two's-complement operands selected by 'sign'.
module div_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sign,
    output logic        busy,
    output logic        done,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [5:0]  count;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] rem;

    logic        accept;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] trial;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] q_final;
    logic [31:0] r_final;
    logic [31:0] zero_rem;

    assign accept = start && ((state == IDLE) || (state == DONE));

    // The dividend register shifts left each cycle; its vacated LSBs collect quotient bits.
    assign trial    = {rem, dvd[31]} - {1'b0, dvs};
    assign rem_next = trial[32] ? {rem[30:0], dvd[31]} : trial[31:0];
    assign quo_next = {dvd[30:0], ~trial[32]};

`ifdef DIV_32_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;
    logic neg_r;

    assign a_neg = sign & A[31];
    assign b_neg = sign & B[31];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end
    end

    // Negating the stored magnitude restores the original A for the zero-divisor case.
    assign q_final  = neg_q ? -quo_next : quo_next;
    assign r_final  = neg_r ? -rem_next : rem_next;
    assign zero_rem = neg_r ? -dvd : dvd;
`else
    logic unused_sign;

    assign unused_sign = sign;
    assign a_mag    = A;
    assign b_mag    = B;
    assign q_final  = quo_next;
    assign r_final  = rem_next;
    assign zero_rem = dvd;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 6'd0;
            dvd         <= 32'd0;
            dvs         <= 32'd0;
            rem         <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            Quotient    <= 32'd0;
            Remainder   <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (accept) begin
                        dvd   <= a_mag;
                        dvs   <= b_mag;
                        rem   <= 32'd0;
                        count <= 6'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (dvs == 32'd0) begin
                        Quotient    <= 32'hFFFF_FFFF;
                        Remainder   <= zero_rem;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        dvd <= quo_next;
                        rem <= rem_next;
                        if (count == 6'd31) begin
                            Quotient    <= q_final;
                            Remainder   <= r_final;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end else begin
                            count <= count + 6'd1;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
